scan_renderer: RTL and testbench

Parametrised, pipelined successor to the fixed 800x600 game renderer. Generates the complete SVGA raster (counters, syncs, blanking) internally and composites ball, paddle and block wall per pixel. Block-alive memory is read through a registered address with one-cycle synchronous read latency. Object positions are latched once per frame, so geometry cannot tear mid-frame. Sits between the game logic (positions, block RAM, FRAME_DONE handshake) and the DAC/pins.

---
 rtl/scan_renderer.sv | 227 ++++++++++++++++++++++
 tb/tb_scan_renderer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_renderer.sv
// scan_renderer: parametrised SVGA raster generator with ball / paddle /
// block-wall compositing and a 2-cycle pixel pipeline.
//
// Optional feature macro: RENDERER_GRID_EN
//   defined   -> 1-px background grid at the top/left edge of every block
//   undefined -> alive blocks are drawn solid (no offset logic built)
//
// Block RAM handshake: the block address for a pixel is presented in the
// same cycle that pixel sits in the stage-0 counters. A 1-cycle synchronous
// RAM then returns BLOCK_ALIVE exactly when that pixel reaches stage 2.
// This keeps the overall pixel latency at two cycles.
module scan_renderer #(
  parameter int unsigned H_ACTIVE        = 800,
  parameter int unsigned H_FP            = 40,
  parameter int unsigned H_SYNC          = 128,
  parameter int unsigned H_BP            = 88,
  parameter int unsigned V_ACTIVE        = 600,
  parameter int unsigned V_FP            = 1,
  parameter int unsigned V_SYNC          = 4,
  parameter int unsigned V_BP            = 23,
  parameter bit          SYNC_POS        = 1'b1,
  parameter int unsigned FRAME_DONE_LINE = 600,
  parameter int unsigned BLOCK_COLS      = 16,
  parameter int unsigned BLOCK_ROWS      = 8,
  parameter int unsigned BLOCK_W_LOG2    = 5,
  parameter int unsigned BLOCK_H_LOG2    = 4,
  parameter int unsigned BLOCK_LEFT      = 144,
  parameter int unsigned BLOCK_TOP       = 64,
  parameter int unsigned ADDR_W          = 7,
  parameter int unsigned PADDLE_Y        = 568,
  parameter int unsigned PADDLE_W        = 64,
  parameter int unsigned PADDLE_H        = 8,
  parameter int unsigned BALL_SIZE       = 8,
  parameter logic [7:0]  BG_COLOR        = 8'h00,
  parameter logic [7:0]  BALL_COLOR      = 8'hFF,
  parameter logic [7:0]  PADDLE_COLOR    = 8'h1C,
  parameter logic [7:0]  BLOCK_COLOR     = 8'hE0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [9:0]        PADDLE_X_PIXEL,
  input  logic [9:0]        BALL_X_PIXEL,
  input  logic [9:0]        BALL_Y_PIXEL,
  output logic [ADDR_W-1:0] BLOCK_ADDR,
  input  logic              BLOCK_ALIVE,
  output logic              FRAME_DONE,
  output logic [7:0]        COLOR,
  output logic              HSYNC,
  output logic              VSYNC
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] FD_LINE  = 11'(FRAME_DONE_LINE);
  localparam logic [10:0] WALL_X0  = 11'(BLOCK_LEFT);
  localparam logic [10:0] WALL_X1  = 11'(BLOCK_LEFT + (BLOCK_COLS << BLOCK_W_LOG2));
  localparam logic [10:0] WALL_Y0  = 11'(BLOCK_TOP);
  localparam logic [10:0] WALL_Y1  = 11'(BLOCK_TOP + (BLOCK_ROWS << BLOCK_H_LOG2));
  localparam logic [10:0] PAD_Y0   = 11'(PADDLE_Y);
  localparam logic [10:0] PAD_Y1   = 11'(PADDLE_Y + PADDLE_H);
  localparam logic [10:0] PAD_LEN  = 11'(PADDLE_W);
  localparam logic [10:0] BALL_LEN = 11'(BALL_SIZE);
  localparam logic [10:0] COLS_11  = 11'(BLOCK_COLS);
  localparam logic        SYNC_OFF = ~SYNC_POS;

  // Half-open unsigned range test used by every geometry comparison.
  function automatic logic in_span(input logic [10:0] v,
                                   input logic [10:0] lo,
                                   input logic [10:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  // ---------------- stage 0: raster counters ----------------
  logic [10:0] x_p0, y_p0;
  logic [10:0] x_nxt, y_nxt;
  logic        last_px_p0;

  // Next raster position; y advances only when x wraps.
  always_comb begin
    x_nxt      = x_p0 + 11'd1;
    y_nxt      = y_p0;
    last_px_p0 = (x_p0 == H_LAST) && (y_p0 == V_LAST);
    if (x_p0 == H_LAST) begin
      x_nxt = 11'd0;
      y_nxt = (y_p0 == V_LAST) ? 11'd0 : (y_p0 + 11'd1);
    end
  end

  // Pixel counters.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      x_p0 <= 11'd0;
      y_p0 <= 11'd0;
    end else begin
      x_p0 <= x_nxt;
      y_p0 <= y_nxt;
    end
  end

  // Shadow positions: captured on the last pixel so a frame never tears.
  logic [10:0] bx_sh, by_sh, px_sh;

  // Latch object positions once per frame.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      bx_sh <= 11'd0;
      by_sh <= 11'd0;
      px_sh <= 11'd0;
    end else if (last_px_p0) begin
      bx_sh <= {1'b0, BALL_X_PIXEL};
      by_sh <= {1'b0, BALL_Y_PIXEL};
      px_sh <= {1'b0, PADDLE_X_PIXEL};
    end
  end

  // Frame-sync pulse straight off the counters, outside the pixel pipeline.
  always_ff @(posedge CLK) begin
    if (!RESET_N) FRAME_DONE <= 1'b0;
    else          FRAME_DONE <= (x_p0 == 11'd0) && (y_p0 == FD_LINE);
  end

  // Block address is computed from the position the counters move to, so
  // it is valid while that pixel sits in stage 0 and the RAM answer lands
  // in time for stage 2.
  logic        wall_nxt;
  logic [10:0] col_nxt, row_nxt;

  // Wall membership and row/column of the upcoming pixel.
  always_comb begin
    wall_nxt = in_span(x_nxt, WALL_X0, WALL_X1) && in_span(y_nxt, WALL_Y0, WALL_Y1);
    col_nxt  = (x_nxt - WALL_X0) >> BLOCK_W_LOG2;
    row_nxt  = (y_nxt - WALL_Y0) >> BLOCK_H_LOG2;
  end

  // Registered RAM address; holds its last value outside the wall.
  always_ff @(posedge CLK) begin
    if (!RESET_N)      BLOCK_ADDR <= '0;
    else if (wall_nxt) BLOCK_ADDR <= ADDR_W'(row_nxt * COLS_11 + col_nxt);
  end

  // ---------------- stage 1: geometry flags ----------------
  logic wall_p1, ball_p1, pad_p1, vld_p1, hs_p1, vs_p1;
  logic wall_c, ball_c, pad_c, vld_c, hs_c, vs_c;

  // Per-pixel hit tests against the shadowed geometry.
  always_comb begin
    wall_c = in_span(x_p0, WALL_X0, WALL_X1) && in_span(y_p0, WALL_Y0, WALL_Y1);
    ball_c = in_span(x_p0, bx_sh, bx_sh + BALL_LEN) && in_span(y_p0, by_sh, by_sh + BALL_LEN);
    pad_c  = in_span(x_p0, px_sh, px_sh + PAD_LEN) && in_span(y_p0, PAD_Y0, PAD_Y1);
    vld_c  = (x_p0 < H_VIS) && (y_p0 < V_VIS);
    hs_c   = in_span(x_p0, HS_BEG, HS_END);
    vs_c   = in_span(y_p0, VS_BEG, VS_END);
  end

  // Stage-1 flag register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wall_p1 <= 1'b0;
      ball_p1 <= 1'b0;
      pad_p1  <= 1'b0;
      vld_p1  <= 1'b0;
      hs_p1   <= 1'b0;
      vs_p1   <= 1'b0;
    end else begin
      wall_p1 <= wall_c;
      ball_p1 <= ball_c;
      pad_p1  <= pad_c;
      vld_p1  <= vld_c;
      hs_p1   <= hs_c;
      vs_p1   <= vs_c;
    end
  end

`ifdef RENDERER_GRID_EN
  localparam logic [10:0] X_MASK = 11'((1 << BLOCK_W_LOG2) - 1);
  localparam logic [10:0] Y_MASK = 11'((1 << BLOCK_H_LOG2) - 1);
  logic grid_p1;

  // Grid line where the in-block x or y offset is zero.
  always_ff @(posedge CLK) begin
    if (!RESET_N) grid_p1 <= 1'b0;
    else          grid_p1 <= (((x_p0 - WALL_X0) & X_MASK) == 11'd0) ||
                             (((y_p0 - WALL_Y0) & Y_MASK) == 11'd0);
  end

  logic block_on;
  assign block_on = wall_p1 && BLOCK_ALIVE && !grid_p1;
`else
  logic block_on;
  assign block_on = wall_p1 && BLOCK_ALIVE;
`endif

  // ---------------- stage 2: colour and syncs ----------------
  logic [7:0] color_c;

  // Compositing priority: ball over paddle over live block over background.
  always_comb begin
    color_c = BG_COLOR;
    if (!vld_p1)      color_c = 8'h00;
    else if (ball_p1) color_c = BALL_COLOR;
    else if (pad_p1)  color_c = PADDLE_COLOR;
    else if (block_on) color_c = BLOCK_COLOR;
  end

  // Output register keeps colour and syncs aligned.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      COLOR <= 8'h00;
      HSYNC <= SYNC_OFF;
      VSYNC <= SYNC_OFF;
    end else begin
      COLOR <= color_c;
      HSYNC <= hs_p1 ^ SYNC_OFF;
      VSYNC <= vs_p1 ^ SYNC_OFF;
    end
  end

endmodule

// File: tb/tb_scan_renderer.sv
// Testbench for scan_renderer using a reduced raster (56x36 total) so
// several frames fit in a short run. Honours RENDERER_GRID_EN.
module tb_scan_renderer;

  localparam int HA = 40, HFP = 4, HSW = 8, HBP = 4;
  localparam int VA = 30, VFP = 1, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;   // 56
  localparam int VT = VA + VFP + VSW + VBP;   // 36
  localparam int FRAME = HT * VT;             // 2016
  localparam int FDL = 30;
  localparam int COLS = 4, ROWS = 2, WL = 2, HL = 1, BW = 4, BH = 2;
  localparam int LEFT = 8, TOP = 4;
  localparam int PY = 26, PW = 8, PH = 2, BS = 3;
`ifdef RENDERER_GRID_EN
  localparam logic [7:0] EDGE_EXP = 8'h00;
`else
  localparam logic [7:0] EDGE_EXP = 8'hE0;
`endif

  logic       CLK, RESET_N;
  logic [9:0] PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL;
  logic [2:0] BLOCK_ADDR;
  logic       BLOCK_ALIVE, FRAME_DONE, HSYNC, VSYNC;
  logic [7:0] COLOR;

  scan_renderer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POS(1'b1), .FRAME_DONE_LINE(FDL),
    .BLOCK_COLS(COLS), .BLOCK_ROWS(ROWS), .BLOCK_W_LOG2(WL), .BLOCK_H_LOG2(HL),
    .BLOCK_LEFT(LEFT), .BLOCK_TOP(TOP), .ADDR_W(3),
    .PADDLE_Y(PY), .PADDLE_W(PW), .PADDLE_H(PH), .BALL_SIZE(BS)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .PADDLE_X_PIXEL(PADDLE_X_PIXEL), .BALL_X_PIXEL(BALL_X_PIXEL), .BALL_Y_PIXEL(BALL_Y_PIXEL),
    .BLOCK_ADDR(BLOCK_ADDR), .BLOCK_ALIVE(BLOCK_ALIVE), .FRAME_DONE(FRAME_DONE),
    .COLOR(COLOR), .HSYNC(HSYNC), .VSYNC(VSYNC)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // 1-cycle synchronous block RAM
  logic mem [0:7];
  always @(posedge CLK) BLOCK_ALIVE <= mem[BLOCK_ADDR];

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int c;                // pixel index now held by the counters (since release)
  int exp_addr;
  int sh_bx [64];
  int sh_by [64];
  int sh_px [64];

  function automatic logic [7:0] model_color(input int p);
    int x, y, f, col, row;
    if (p < 0) return 8'h00;
    x = p % HT;
    y = (p / HT) % VT;
    f = p / FRAME;
    if (f > 63) f = 63;
    if (!(x < HA && y < VA)) return 8'h00;
    if (x >= sh_bx[f] && x < sh_bx[f] + BS && y >= sh_by[f] && y < sh_by[f] + BS) return 8'hFF;
    if (x >= sh_px[f] && x < sh_px[f] + PW && y >= PY && y < PY + PH) return 8'h1C;
    if (x >= LEFT && x < LEFT + COLS * BW && y >= TOP && y < TOP + ROWS * BH) begin
      col = (x - LEFT) / BW;
      row = (y - TOP) / BH;
`ifdef RENDERER_GRID_EN
      if ((x - LEFT) % BW == 0 || (y - TOP) % BH == 0) return 8'h00;
`endif
      if (mem[row * COLS + col]) return 8'hE0;
    end
    return 8'h00;
  endfunction

  function automatic logic model_hs(input int p);
    int x;
    if (p < 0) return 1'b0;
    x = p % HT;
    return (x >= HA + HFP && x < HA + HFP + HSW);
  endfunction

  function automatic logic model_vs(input int p);
    int y;
    if (p < 0) return 1'b0;
    y = (p / HT) % VT;
    return (y >= VA + VFP && y < VA + VFP + VSW);
  endfunction

  function automatic logic model_fd(input int cc);
    if (cc < 1) return 1'b0;
    return ((cc - 1) % FRAME) == FDL * HT;
  endfunction

  function automatic logic model_in_wall(input int p);
    int x, y;
    x = p % HT;
    y = (p / HT) % VT;
    return (x >= LEFT && x < LEFT + COLS * BW && y >= TOP && y < TOP + ROWS * BH);
  endfunction

  function automatic int model_addr(input int p);
    int x, y;
    x = p % HT;
    y = (p / HT) % VT;
    return ((y - TOP) / BH) * COLS + (x - LEFT) / BW;
  endfunction

  // Per-cycle compare against the model
  initial begin
    c = 0;
    exp_addr = 0;
    forever begin
      @(posedge CLK);
      if (!RESET_N) begin
        c = 0;
        exp_addr = 0;
        for (int i = 0; i < 64; i++) begin
          sh_bx[i] = 0; sh_by[i] = 0; sh_px[i] = 0;
        end
      end else begin
        if (c % FRAME == FRAME - 1 && c / FRAME + 1 < 64) begin
          sh_bx[c / FRAME + 1] = int'(BALL_X_PIXEL);
          sh_by[c / FRAME + 1] = int'(BALL_Y_PIXEL);
          sh_px[c / FRAME + 1] = int'(PADDLE_X_PIXEL);
        end
        c++;
        if (model_in_wall(c)) exp_addr = model_addr(c);
      end
      #1;
      chk("color", COLOR, model_color(c - 2));
      chk("hsync", HSYNC, model_hs(c - 2));
      chk("vsync", VSYNC, model_vs(c - 2));
      chk("frame_done", FRAME_DONE, model_fd(c));
      chk("block_addr", BLOCK_ADDR, exp_addr);
    end
  end

  // ---------------- directed stimulus helpers ----------------
  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return HSYNC;
      1:       return VSYNC;
      default: return FRAME_DONE;
    endcase
  endfunction

  task automatic wait_edge(input string nm, input int sel, input logic lvl,
                           input int bound, output int n);
    n = 0;
    do begin
      @(posedge CLK); #2;
      n++;
    end while (get_sig(sel) != lvl && n < bound);
    chk(nm, get_sig(sel), lvl);
  endtask

  // wait until pixel (x,y) is on COLOR, then compare with a literal
  task automatic wait_pix(input string nm, input int x, input int y, input logic [7:0] exp);
    int n;
    logic hit;
    n = 0;
    hit = 1'b0;
    do begin
      @(posedge CLK); #2;
      n++;
      hit = (c >= 2) && ((c - 2) % FRAME == y * HT + x);
    end while (!hit && n < FRAME + 8);
    chk({nm, "_reach"}, hit, 1'b1);
    chk(nm, COLOR, exp);
  endtask

  // wait until the counters hold pixel (x,y)
  task automatic wait_p0(input int x, input int y);
    int n;
    n = 0;
    do begin
      @(posedge CLK); #2;
      n++;
    end while ((c % FRAME) != y * HT + x && n < FRAME + 8);
    chk("p0_reach", (c % FRAME) == y * HT + x, 1'b1);
  endtask

  int n, n2;

  initial begin
    RESET_N = 1'b0;
    BALL_X_PIXEL = 10'd1000;
    BALL_Y_PIXEL = 10'd1000;
    PADDLE_X_PIXEL = 10'd1000;
    for (int i = 0; i < 8; i++) mem[i] = 1'b1;

    // reset values
    repeat (3) @(negedge CLK);
    chk("rst_color", COLOR, 8'h00);
    chk("rst_hsync", HSYNC, 1'b0);
    chk("rst_vsync", VSYNC, 1'b0);
    chk("rst_fd", FRAME_DONE, 1'b0);
    chk("rst_addr", BLOCK_ADDR, 3'd0);

    // first HSYNC after release: x reaches 44, plus 2 cycles latency
    @(negedge CLK); RESET_N = 1'b1;
    wait_edge("first_hs", 0, 1'b1, 200, n);
    chk("first_hs_cycles", n, HA + HFP + 2);

    // sync and frame timing
    wait_edge("hs_fall", 0, 1'b0, HT + 4, n);
    wait_edge("hs_rise", 0, 1'b1, HT + 4, n2);
    chk("hs_width", n, HSW);
    chk("hs_period", n + n2, HT);
    wait_edge("vs_rise", 1, 1'b1, FRAME + 8, n);
    wait_edge("vs_fall", 1, 1'b0, FRAME + 8, n);
    wait_edge("vs_rise2", 1, 1'b1, FRAME + 8, n2);
    chk("vs_width", n, VSW * HT);
    chk("vs_period", n + n2, FRAME);
    wait_edge("fd_rise", 2, 1'b1, FRAME + 8, n);
    wait_edge("fd_fall", 2, 1'b0, FRAME + 8, n);
    wait_edge("fd_rise2", 2, 1'b1, FRAME + 8, n2);
    chk("fd_width", n, 1);
    chk("fd_spacing", n + n2, FRAME);

    // pin the model: frame 2 has everything off-screen, all blocks alive
    chk("model_wall_tl", model_color(2 * FRAME + 4 * HT + 8), EDGE_EXP);
    chk("model_left_of_wall", model_color(2 * FRAME + 4 * HT + 7), 8'h00);
    chk("model_addr_12_6", model_addr(6 * HT + 12), 5);

    // wall edges, all alive, objects off-screen
    wait_pix("wall_7_4", 7, 4, 8'h00);
    wait_pix("wall_8_4", 8, 4, EDGE_EXP);
    wait_pix("wall_9_5", 9, 5, 8'hE0);
    wait_pix("wall_12_5", 12, 5, EDGE_EXP);
    wait_pix("wall_23_7", 23, 7, 8'hE0);
    wait_pix("wall_24_7", 24, 7, 8'h00);
    wait_p0(12, 6);
    chk("addr_12_6", BLOCK_ADDR, 3'd5);

    // ball over paddle
    BALL_X_PIXEL = 10'd10;
    BALL_Y_PIXEL = 10'd26;
    PADDLE_X_PIXEL = 10'd8;
    wait_edge("fd_b", 2, 1'b1, FRAME + 8, n);
    wait_pix("paddle_only", 8, 26, 8'h1C);
    wait_pix("ball_over_paddle", 11, 26, 8'hFF);
    wait_pix("blanking", 45, 26, 8'h00);

    // mid-frame position change takes effect next frame only
    wait_p0(0, 15);
    BALL_X_PIXEL = 10'd20;
    wait_pix("old_ball", 11, 26, 8'hFF);
    wait_pix("old_empty", 21, 26, 8'h00);
    wait_edge("fd_c", 2, 1'b1, FRAME + 8, n);
    wait_pix("new_paddle", 11, 26, 8'h1C);
    wait_pix("new_ball", 21, 26, 8'hFF);

    // reset mid-frame
    wait_p0(25, 15);
    RESET_N = 1'b0;
    @(posedge CLK); #2;
    chk("mid_rst_color", COLOR, 8'h00);
    chk("mid_rst_hsync", HSYNC, 1'b0);
    chk("mid_rst_vsync", VSYNC, 1'b0);
    chk("mid_rst_fd", FRAME_DONE, 1'b0);
    chk("mid_rst_addr", BLOCK_ADDR, 3'd0);
    for (int i = 0; i < 8; i++) mem[i] = (8'hA6 >> i) & 8'h01;
    @(negedge CLK); RESET_N = 1'b1;
    wait_edge("first_hs_2", 0, 1'b1, 200, n);
    chk("first_hs_2_cycles", n, HA + HFP + 2);

    // patterned wall, frame 0 after reset (shadows are zero)
    wait_pix("pat_9_5", 9, 5, 8'h00);
    wait_pix("pat_13_5", 13, 5, 8'hE0);
    wait_pix("pat_17_7", 17, 7, 8'h00);
    wait_pix("pat_21_7", 21, 7, 8'hE0);

    repeat (20) @(posedge CLK);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
